// File: rtl/acam_clk_pkg.sv
// Shared clocking definitions for the acoustic-camera capture path:
// sequencer state encoding, default timing constants and the PSDA width.
package acam_clk_pkg;

    typedef enum logic [2:0] {
        PLLRST = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAIL   = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 27000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRY     = 3;
    localparam int DEF_PHASE_SETTLE  = 64;

    localparam int PSDA_W = 4;

    // Used to size the shared down-counter for the longest interval it must time.
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for single-bit or bus signals whose bits
// change independently (lock indication, I2S word select). Clears to 0.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // First stage may go metastable; the second gives it a full cycle to resolve.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// Board PLL supervisor: sequences the PLL reset, waits for lock with a
// timeout, qualifies lock over a stability window and only then releases
// sys_rst to the downstream capture logic. Retries on failure or loss.
// Optional PSDA phase stepping is built when PLL_PHASE_CTRL_EN is defined;
// otherwise the phase ports are absent and psda is tied to zero.
module pll_lock_sequencer
    import acam_clk_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRY     = DEF_MAX_RETRY,
    parameter int PHASE_SETTLE  = DEF_PHASE_SETTLE
) (
    input  logic                               clkin,
    input  logic                               reset,
    input  logic                               lock,
`ifdef PLL_PHASE_CTRL_EN
    input  logic                               phase_req,
    input  logic [PSDA_W-1:0]                  phase_val,
    output logic                               phase_ack,
`endif
    output logic                               pll_reset,
    output logic [PSDA_W-1:0]                  psda,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
    output logic [7:0]                         loss_cnt
);

    localparam int CNT_MAX = max_of(max_of(RST_CYCLES, LOCK_TIMEOUT),
                                    max_of(STABLE_CYCLES, PHASE_SETTLE));
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RW      = $clog2(MAX_RETRY + 1);

    logic        lock_s;
    logic        accept;

    pll_state_e  state_q,    state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [RW-1:0] retryCnt_q, retryCnt_d;
    logic [7:0]  lossCnt_q,  lossCnt_d;
    logic        settle_q,   settle_d;
    logic        pllReset_q, pllReset_d;
    logic        sysRst_q,   sysRst_d;
    logic        ready_q,    ready_d;
    logic        fail_q,     fail_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i   (clkin),
        .reset_i (reset),
        .d_i     (lock),
        .q_o     (lock_s)
    );

`ifdef PLL_PHASE_CTRL_EN
    logic [PSDA_W-1:0] psda_q,     psda_d;
    logic              phaseAck_q, phaseAck_d;

    // A step is taken only while the clock is up, locked and not already settling.
    assign accept = (state_q == RUN) && lock_s && !settle_q && phase_req;

    // Latch the new phase and pulse the acknowledge on the acceptance edge.
    always_comb begin
        psda_d     = accept ? phase_val : psda_q;
        phaseAck_d = accept;
    end

    // Phase registers keep their value across lock loss; only reset clears them.
    always_ff @(posedge clkin) begin
        if (reset) begin
            psda_q     <= '0;
            phaseAck_q <= 1'b0;
        end else begin
            psda_q     <= psda_d;
            phaseAck_q <= phaseAck_d;
        end
    end

    assign psda      = psda_q;
    assign phase_ack = phaseAck_q;
`else
    assign accept = 1'b0;
    assign psda   = '0;
`endif

    // State, shared counter, bookkeeping counters and registered outputs.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q    <= PLLRST;
            cnt_q      <= CW'(RST_CYCLES - 1);
            retryCnt_q <= '0;
            lossCnt_q  <= '0;
            settle_q   <= 1'b0;
            pllReset_q <= 1'b1;
            sysRst_q   <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retryCnt_q <= retryCnt_d;
            lossCnt_q  <= lossCnt_d;
            settle_q   <= settle_d;
            pllReset_q <= pllReset_d;
            sysRst_q   <= sysRst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    // Next-state logic; the shared counter is reloaded on every state entry.
    // STABLE loads the full window because its entry cycle is not counted.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retryCnt_d = retryCnt_q;
        lossCnt_d  = lossCnt_q;
        settle_d   = settle_q;

        unique case (state_q)
            PLLRST: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LOCK_TIMEOUT - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = CW'(STABLE_CYCLES);
                end else if (cnt_q == '0) begin
                    retryCnt_d = retryCnt_q + RW'(1);
                    if (retryCnt_q == RW'(MAX_RETRY - 1)) begin
                        state_d = FAIL;
                        cnt_d   = '0;
                    end else begin
                        state_d = PLLRST;
                        cnt_d   = CW'(RST_CYCLES - 1);
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LOCK_TIMEOUT - 1);
                end else if (cnt_q == '0) begin
                    state_d    = RUN;
                    cnt_d      = '0;
                    retryCnt_d = '0;
                    settle_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d  = PLLRST;
                    cnt_d    = CW'(RST_CYCLES - 1);
                    settle_d = 1'b0;
                    if (lossCnt_q != 8'hFF) begin
                        lossCnt_d = lossCnt_q + 8'd1;
                    end
                end else if (accept) begin
                    settle_d = 1'b1;
                    cnt_d    = CW'(PHASE_SETTLE - 1);
                end else if (settle_q) begin
                    if (cnt_q == '0) begin
                        settle_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            FAIL: begin
                state_d = FAIL;
            end
            default: begin
                state_d = PLLRST;
                cnt_d   = CW'(RST_CYCLES - 1);
            end
        endcase
    end

    // Outputs decoded from the next state so they change on the transition edge.
    always_comb begin
        pllReset_d = (state_d == PLLRST) || (state_d == FAIL);
        sysRst_d   = (state_d != RUN);
        ready_d    = (state_d == RUN) && !settle_d;
        fail_d     = (state_d == FAIL);
    end

    assign pll_reset = pllReset_q;
    assign sys_rst   = sysRst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign retry_cnt = retryCnt_q;
    assign loss_cnt  = lossCnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer with shrunk timing parameters.
// Cycle numbers count clock edges after the edge that sampled reset high.
module tb_pll_lock_sequencer;

    localparam int SIG_PLLRST = 0;
    localparam int SIG_SYSRST = 1;
    localparam int SIG_READY  = 2;
    localparam int SIG_FAILO  = 3;
    localparam int SIG_RETRY  = 4;
    localparam int SIG_LOSS   = 5;
    localparam int SIG_PSDA   = 6;
    localparam int SIG_ACK    = 7;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       tag;
    } exp_t;

    logic       clkin = 1'b0;
    logic       reset = 1'b0;
    logic       lock  = 1'b0;
    logic       pll_reset;
    logic [3:0] psda;
    logic       sys_rst;
    logic       ready;
    logic       fail;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;
`ifdef PLL_PHASE_CTRL_EN
    logic       phase_req = 1'b0;
    logic [3:0] phase_val = 4'h0;
    logic       phase_ack;
`endif

    exp_t sb[$];
    int   cyc     = 0;
    int   nChecks = 0;
    int   nFails  = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (50),
        .STABLE_CYCLES (8),
        .MAX_RETRY     (3),
        .PHASE_SETTLE  (5)
    ) dut (
        .clkin     (clkin),
        .reset     (reset),
        .lock      (lock),
`ifdef PLL_PHASE_CTRL_EN
        .phase_req (phase_req),
        .phase_val (phase_val),
        .phase_ack (phase_ack),
`endif
        .pll_reset (pll_reset),
        .psda      (psda),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    always #5 clkin = ~clkin;

    function automatic logic [31:0] probe(input int sig);
        case (sig)
            SIG_PLLRST: probe = {31'b0, pll_reset};
            SIG_SYSRST: probe = {31'b0, sys_rst};
            SIG_READY:  probe = {31'b0, ready};
            SIG_FAILO:  probe = {31'b0, fail};
            SIG_RETRY:  probe = {30'b0, retry_cnt};
            SIG_LOSS:   probe = {24'b0, loss_cnt};
            SIG_PSDA:   probe = {28'b0, psda};
`ifdef PLL_PHASE_CTRL_EN
            SIG_ACK:    probe = {31'b0, phase_ack};
`endif
            default:    probe = 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic expectAt(input int c, input int s, input logic [31:0] v, input string t);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        e.tag = t;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clkin);
        #1;
        cyc++;
    endtask

    task automatic applyReset();
        @(negedge clkin);
        reset = 1'b1;
        @(posedge clkin);
        #1;
        reset = 1'b0;
        cyc   = 0;
    endtask

    // Reset values, with lock already high to show reset wins over a lock event.
    task automatic test_reset();
        exp_t e;
        lock = 1'b1;
        applyReset();
        expectAt(0, SIG_PLLRST, 1, "rst_pll_reset");
        expectAt(0, SIG_SYSRST, 1, "rst_sys_rst");
        expectAt(0, SIG_READY,  0, "rst_ready");
        expectAt(0, SIG_FAILO,  0, "rst_fail");
        expectAt(0, SIG_RETRY,  0, "rst_retry_cnt");
        expectAt(0, SIG_LOSS,   0, "rst_loss_cnt");
        expectAt(0, SIG_PSDA,   0, "rst_psda");
`ifdef PLL_PHASE_CTRL_EN
        expectAt(0, SIG_ACK,    0, "rst_phase_ack");
`endif
        expectAt(3, SIG_PLLRST, 1, "rst_pll_reset_hold");
        expectAt(4, SIG_PLLRST, 0, "rst_pll_reset_fall");
        for (int k = 0; k <= 5; k++) begin
            if (k > 0) step();
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_reset: %0d expectations never reached", sb.size());
            sb.delete();
        end
        lock = 1'b0;
    endtask

    // Normal bring-up: lock at cycle 10, ready at 10+2+1+8+1 = 22.
    task automatic test_bringup();
        exp_t e;
        lock = 1'b0;
        applyReset();
        expectAt(3,  SIG_PLLRST, 1, "up_pll_reset_hold");
        expectAt(4,  SIG_PLLRST, 0, "up_pll_reset_fall");
        expectAt(21, SIG_READY,  0, "up_ready_early");
        expectAt(21, SIG_SYSRST, 1, "up_sys_rst_early");
        expectAt(22, SIG_READY,  1, "up_ready");
        expectAt(22, SIG_SYSRST, 0, "up_sys_rst");
        expectAt(22, SIG_RETRY,  0, "up_retry_cnt");
        expectAt(22, SIG_PSDA,   0, "up_psda");
        expectAt(22, SIG_PLLRST, 0, "up_pll_reset_run");
        for (int k = 0; k < 25; k++) begin
            step();
            if (cyc == 10) lock = 1'b1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_bringup: %0d expectations never reached", sb.size());
            sb.delete();
        end
    endtask

    // No lock: timeouts at 54, 108, 162 (4 reset + 50 wait each); terminal after the third.
    task automatic test_retry_exhaust();
        exp_t e;
        lock = 1'b0;
        applyReset();
        expectAt(53,  SIG_RETRY,  0, "rx_retry_before1");
        expectAt(54,  SIG_RETRY,  1, "rx_retry1");
        expectAt(57,  SIG_PLLRST, 1, "rx_pll_reset_retry");
        expectAt(58,  SIG_PLLRST, 0, "rx_pll_reset_release");
        expectAt(107, SIG_RETRY,  1, "rx_retry_before2");
        expectAt(108, SIG_RETRY,  2, "rx_retry2");
        expectAt(161, SIG_FAILO,  0, "rx_fail_early");
        expectAt(161, SIG_PLLRST, 0, "rx_pll_reset_wait");
        expectAt(162, SIG_RETRY,  3, "rx_retry3");
        expectAt(162, SIG_FAILO,  1, "rx_fail");
        expectAt(162, SIG_PLLRST, 1, "rx_pll_reset_fail");
        expectAt(362, SIG_FAILO,  1, "rx_fail_sticky");
        expectAt(362, SIG_PLLRST, 1, "rx_pll_reset_sticky");
        expectAt(362, SIG_SYSRST, 1, "rx_sys_rst_sticky");
        expectAt(362, SIG_READY,  0, "rx_ready_sticky");
        for (int k = 0; k < 363; k++) begin
            step();
            if (cyc == 200) lock = 1'b1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_retry_exhaust: %0d expectations never reached", sb.size());
            sb.delete();
        end
        lock = 1'b0;
    endtask

    // One-cycle lock drop after cycle 16 sends STABLE back to WAIT; ready moves from 22 to 29.
    task automatic test_stable_glitch();
        exp_t e;
        lock = 1'b0;
        applyReset();
        expectAt(19, SIG_PLLRST, 0, "gl_pll_reset_low");
        expectAt(19, SIG_RETRY,  0, "gl_retry_after_drop");
        expectAt(22, SIG_READY,  0, "gl_ready_not_at_22");
        expectAt(28, SIG_READY,  0, "gl_ready_early");
        expectAt(29, SIG_READY,  1, "gl_ready");
        expectAt(29, SIG_SYSRST, 0, "gl_sys_rst");
        expectAt(29, SIG_RETRY,  0, "gl_retry_run");
        for (int k = 0; k < 32; k++) begin
            step();
            if (cyc == 10) lock = 1'b1;
            if (cyc == 16) lock = 1'b0;
            if (cyc == 17) lock = 1'b1;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_stable_glitch: %0d expectations never reached", sb.size());
            sb.delete();
        end
    endtask

    // Lock loss after cycle 30 in RUN, relock after 40, then a reset pulse clears loss_cnt.
    task automatic test_lock_loss();
        exp_t e;
        lock = 1'b0;
        applyReset();
        expectAt(22, SIG_READY,  1, "ll_ready_first");
        expectAt(32, SIG_SYSRST, 0, "ll_sys_rst_before");
        expectAt(32, SIG_PLLRST, 0, "ll_pll_reset_before");
        expectAt(33, SIG_SYSRST, 1, "ll_sys_rst");
        expectAt(33, SIG_READY,  0, "ll_ready_drop");
        expectAt(33, SIG_PLLRST, 1, "ll_pll_reset");
        expectAt(33, SIG_LOSS,   1, "ll_loss_cnt");
        expectAt(33, SIG_RETRY,  0, "ll_retry_unchanged");
        expectAt(36, SIG_PLLRST, 1, "ll_pll_reset_hold");
        expectAt(37, SIG_PLLRST, 0, "ll_pll_reset_fall");
        expectAt(51, SIG_READY,  0, "ll_ready_early");
        expectAt(52, SIG_READY,  1, "ll_ready_relock");
        expectAt(52, SIG_LOSS,   1, "ll_loss_kept");
        expectAt(56, SIG_LOSS,   0, "ll_reset_loss_cnt");
        expectAt(56, SIG_READY,  0, "ll_reset_ready");
        expectAt(56, SIG_SYSRST, 1, "ll_reset_sys_rst");
        expectAt(56, SIG_PLLRST, 1, "ll_reset_pll_reset");
        for (int k = 0; k < 58; k++) begin
            step();
            if (cyc == 10) lock = 1'b1;
            if (cyc == 30) lock = 1'b0;
            if (cyc == 40) lock = 1'b1;
            if (cyc == 55) reset = 1'b1;
            if (cyc == 56) reset = 1'b0;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_lock_loss: %0d expectations never reached", sb.size());
            sb.delete();
        end
        lock = 1'b0;
    endtask

    // Lock held from cycle 0, reset pulsed mid-STABLE (sampled at 9); the sequence replays from 9.
    task automatic test_reset_mid_stable();
        exp_t e;
        lock = 1'b0;
        applyReset();
        lock = 1'b1;
        expectAt(9,  SIG_PLLRST, 1, "rm_pll_reset");
        expectAt(9,  SIG_SYSRST, 1, "rm_sys_rst");
        expectAt(9,  SIG_READY,  0, "rm_ready");
        expectAt(9,  SIG_RETRY,  0, "rm_retry_cnt");
        expectAt(12, SIG_PLLRST, 1, "rm_pll_reset_hold");
        expectAt(13, SIG_PLLRST, 0, "rm_pll_reset_fall");
        expectAt(14, SIG_READY,  0, "rm_ready_not_at_14");
        expectAt(22, SIG_READY,  0, "rm_ready_early");
        expectAt(23, SIG_READY,  1, "rm_ready");
        expectAt(23, SIG_SYSRST, 0, "rm_sys_rst_run");
        for (int k = 0; k < 25; k++) begin
            step();
            if (cyc == 8) reset = 1'b1;
            if (cyc == 9) reset = 1'b0;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_reset_mid_stable: %0d expectations never reached", sb.size());
            sb.delete();
        end
        lock = 1'b0;
    endtask

`ifdef PLL_PHASE_CTRL_EN
    // Request raised in STABLE at 14; RUN at 22, accepted at 23, ready back at 23+5 = 28.
    task automatic test_phase_step();
        exp_t e;
        lock = 1'b0;
        applyReset();
        expectAt(15, SIG_ACK,    0, "ph_no_ack_stable");
        expectAt(20, SIG_ACK,    0, "ph_no_ack_stable2");
        expectAt(22, SIG_ACK,    0, "ph_no_ack_run_entry");
        expectAt(22, SIG_PSDA,   0, "ph_psda_before");
        expectAt(22, SIG_READY,  1, "ph_ready_run");
        expectAt(23, SIG_ACK,    1, "ph_ack");
        expectAt(23, SIG_PSDA,   9, "ph_psda");
        expectAt(23, SIG_READY,  0, "ph_ready_settle_start");
        expectAt(23, SIG_SYSRST, 0, "ph_sys_rst_settle");
        expectAt(24, SIG_ACK,    0, "ph_ack_single");
        expectAt(27, SIG_READY,  0, "ph_ready_settle_end");
        expectAt(27, SIG_SYSRST, 0, "ph_sys_rst_settle2");
        expectAt(28, SIG_READY,  1, "ph_ready_back");
        expectAt(30, SIG_PSDA,   9, "ph_psda_kept");
        expectAt(30, SIG_ACK,    0, "ph_no_second_ack");
        for (int k = 0; k < 31; k++) begin
            step();
            if (cyc == 10) lock = 1'b1;
            if (cyc == 14) begin
                phase_req = 1'b1;
                phase_val = 4'h9;
            end
            if (cyc == 23) phase_req = 1'b0;
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                nChecks++;
                if (probe(e.sig) !== e.val) begin
                    nFails++;
                    $display("[TB] FAIL %s at cycle %0d: observed %0h, expected %0h", e.tag, cyc, probe(e.sig), e.val);
                end
            end
        end
        if (sb.size() != 0) begin
            nChecks++; nFails++;
            $display("[TB] FAIL test_phase_step: %0d expectations never reached", sb.size());
            sb.delete();
        end
        lock = 1'b0;
    endtask
`endif

    initial begin
        $display("[TB] pll_lock_sequencer bench start");
        test_reset();
        test_bringup();
        test_retry_exhaust();
        test_stable_glitch();
        test_lock_loss();
        test_reset_mid_stable();
`ifdef PLL_PHASE_CTRL_EN
        test_phase_step();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pll_lock_sequencer.md
# pll_lock_sequencer

Supervises the board PLL (27 MHz reference in, 81 MHz out) for the acoustic-camera capture path. It sequences the PLL reset, waits for lock with a timeout, and qualifies lock over a stability window. Only then does it release the synchronous reset for downstream logic (I2S capture, beamforming). It retries on lock failure or loss, and optionally steps the PLL output phase (PSDA) on request.

## Interface
Parameters:
- RST_CYCLES, 16: cycles `pll_reset` is held high per attempt.
- LOCK_TIMEOUT, 27000: cycles to wait for lock per attempt (1 ms at 27 MHz).
- STABLE_CYCLES, 1024: consecutive synced-lock cycles required before release.
- MAX_RETRY, 3: failed lock attempts allowed before terminal failure.
- PHASE_SETTLE, 64: cycles `ready` stays low after a phase step (PLL_PHASE_CTRL_EN only).

Ports:
- `clkin` in 1: free-running 27 MHz reference; the block runs entirely on it.
- `reset` in 1: synchronous, active-high.
- `lock` in 1: PLL lock, asynchronous to `clkin`.
- `pll_reset` out 1: PLL reset.
- `psda` out 4: PLL phase-shift select.
- `sys_rst` out 1: synchronous active-high reset for consumers of the PLL clock.
- `ready` out 1: PLL clock valid and settled.
- `fail` out 1: retries exhausted; sticky.
- `retry_cnt` out $clog2(MAX_RETRY+1): failed attempts in the current bring-up.
- `loss_cnt` out 8: lock-loss events while in RUN, saturating at 255.
- `phase_req` in 1: phase-step request (macro only).
- `phase_val` in 4: requested PSDA value (macro only).
- `phase_ack` out 1: one-cycle acceptance pulse (macro only).

## Operation
- `lock` passes through a 2-flop synchronizer to give `lock_s`. All FSM decisions use `lock_s`.
- States and outputs:
  - PLLRST: `pll_reset`=1, `sys_rst`=1, `ready`=0.
  - WAIT: `pll_reset`=0.
  - STABLE: `pll_reset`=0.
  - RUN: `sys_rst`=0, `ready`=1 except during phase settle.
  - FAIL: `pll_reset`=1, `sys_rst`=1, `fail`=1.
- One shared down-counter is reloaded on every state entry.
- Transitions:
  - PLLRST → WAIT after RST_CYCLES cycles.
  - WAIT → STABLE when `lock_s`=1.
  - WAIT timeout (LOCK_TIMEOUT cycles without lock): `retry_cnt`+1. If the new value equals MAX_RETRY → FAIL, else → PLLRST.
  - STABLE → WAIT if `lock_s` drops. The WAIT timeout restarts and no retry is counted.
  - STABLE → RUN after STABLE_CYCLES consecutive `lock_s`=1. On this transition `retry_cnt` is cleared.
  - RUN → PLLRST when `lock_s`=0. `loss_cnt` increments with saturation; `retry_cnt` is unchanged.
  - FAIL is terminal until `reset`.
- Reset values:
  - `pll_reset`=1, `sys_rst`=1, `psda`=0.
  - `ready`=0, `fail`=0, `retry_cnt`=0, `loss_cnt`=0, `phase_ack`=0.
  - Synchronizer flops=0; state=PLLRST.
  - `reset` asserted mid-operation: all of the above next cycle, regardless of state.
- `reset` and a lock event in the same cycle: reset wins.

## Timing
- All outputs are registered.
- `lock` rising edge → earliest `ready`=1: 2 (sync) + 1 (WAIT→STABLE) + STABLE_CYCLES + 1 cycles.
- `lock` falling edge in RUN → `sys_rst`=1 and `ready`=0 exactly 3 cycles later.
- `pll_reset` rises on the same edge that `sys_rst` rises.
- After `reset` deasserts, `pll_reset` stays high exactly RST_CYCLES cycles.

## Configuration
Macro: PLL_PHASE_CTRL_EN.
- Defined:
  - `phase_req`, `phase_val` and `phase_ack` exist.
  - `phase_req` is level-held by the requester until `phase_ack`.
  - Accepted only in RUN and not during settle. Requests in other states wait.
  - On acceptance: `psda`←`phase_val` and `phase_ack`=1 for one cycle, both on the next edge. `ready`=0 for PHASE_SETTLE cycles, then 1. `sys_rst` stays 0.
  - A lock loss during settle follows the normal RUN → PLLRST path. `psda` keeps its value.
- Undefined: phase ports are absent and `psda` is constant 4'b0000.

## Structure
- Shared package `acam_clk_pkg` holds:
  - The state enum (PLLRST, WAIT, STABLE, RUN, FAIL).
  - Default-parameter constants.
  - The PSDA width constant (4).
- One sub-module, `sync_2ff`: a generic 2-flop synchronizer, reset value 0, reusable for I2S word-select crossing.
- FSM, counters and phase logic stay in `pll_lock_sequencer`.

## Test plan
Shrink the parameters to RST=4, TIMEOUT=50, STABLE=8, MAX_RETRY=3, SETTLE=5.
- Normal bring-up: release `reset`; drive `lock`=1 at cycle 10 → `pll_reset` falls at cycle 4; `ready`=1 and `sys_rst`=0 at cycle 10+2+1+8+1=22.
- Retry exhaustion: `lock` held 0 → `retry_cnt` goes 1, 2, 3 at each timeout; `fail`=1 and `pll_reset`=1 after the third timeout and stay there for 200 further cycles.
- Lock glitch in STABLE: `lock` low for 1 cycle mid-window → return to WAIT, `retry_cnt` stays 0, `ready` delayed by a full new window.
- Lock loss in RUN: `lock`=0 → `sys_rst`=1 three cycles later, `loss_cnt`=1, `pll_reset` pulses for 4 cycles, recovery to `ready`=1 on relock.
- Reset mid-STABLE: assert `reset` for 1 cycle → all outputs return to reset values next cycle, then the full sequence replays.
- Phase step (macro defined): `phase_req`=1 with `phase_val`=4'h9 while in STABLE → no ack until RUN; then `phase_ack` pulses once, `psda`=9, `ready` low for 5 cycles, `sys_rst` stays 0.
